gate_bist_ctrl: RTL

//  Synthesizable built-in self-test sequencer for small combinational gates.

---
 rtl/gate_bist_pkg.sv | 20 ++
 rtl/gate_bist_if.sv | 27 ++
 rtl/gate_bist_sync.sv | 24 ++
 rtl/gate_bist_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate BIST controller: FSM state encoding and
// reference truth tables for common two-input gates.
package gate_bist_pkg;

  typedef logic [2:0] bist_state_t;

  localparam bist_state_t StIdle   = 3'd0;
  localparam bist_state_t StApply  = 3'd1;
  localparam bist_state_t StSettle = 3'd2;
  localparam bist_state_t StCheck  = 3'd3;
  localparam bist_state_t StDone   = 3'd4;

  // Bit i is the expected gate output for input vector i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_if.sv
// Control/result and gate-under-test signals of the gate BIST controller.
// master: host and gate side; slave: the controller.
interface gate_bist_if #(
  parameter int unsigned N_IN = 2
);
  localparam int unsigned NV = 1 << N_IN;

  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_cnt;
  logic [NV-1:0]   fail_vec;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_cnt, fail_vec
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_cnt, fail_vec
  );

endinterface

// File: rtl/gate_bist_sync.sv
// Two-flop synchronizer for the gate-under-test output; resets to 0.
module gate_bist_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: walks every input vector of a small gate, samples its output after a
// settle time and compares against EXP_TT. Define GATE_BIST_SYNC_EN to synchronise dut_out.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned              N_IN       = 2,
  parameter int unsigned              SETTLE_CYC = 10,
  parameter logic [(1 << N_IN)-1:0]   EXP_TT     = TT_AND
) (
  input logic          clk,
  input logic          rst_n,
  gate_bist_if.slave   bus
);

  localparam int unsigned NV = 1 << N_IN;
`ifdef GATE_BIST_SYNC_EN
  localparam int unsigned SyncLat = 2;
`else
  localparam int unsigned SyncLat = 0;
`endif
  localparam int unsigned     SettleTot  = SETTLE_CYC + SyncLat;
  localparam logic [8:0]      SettleLast = (SettleTot == 0) ? 9'd0 : 9'(SettleTot - 1);
  localparam logic [N_IN-1:0] IdxLast    = N_IN'(NV - 1);

  bist_state_t     state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic [NV-1:0]   fail_vec_q, fail_vec_d;

  logic dut_out_s;
  logic mismatch;

`ifdef GATE_BIST_SYNC_EN
  gate_bist_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.dut_out),
    .q_o   (dut_out_s)
  );
`else
  assign dut_out_s = bus.dut_out;
`endif

  // Case inequality so an X/Z gate output is flagged in simulation.
  assign mismatch = (dut_out_s !== EXP_TT[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    fail_vec_d = fail_vec_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d    = StApply;
          idx_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_cnt_d = '0;
          fail_vec_d = '0;
        end
      end
      StApply: begin
        dut_in_d = idx_q;
        cnt_d    = '0;
        state_d  = (SettleTot == 0) ? StCheck : StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          fail_vec_d[idx_q] = 1'b1;
          fail_cnt_d        = fail_cnt_q + 1'b1;
        end
        if (idx_q == IdxLast) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign bus.dut_in   = dut_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.fail_vec = fail_vec_q;

endmodule
